// File: rtl/divider_ratio_ctrl.sv
// ---------------------------------------------------------------------------
// divider_ratio_ctrl
//   Run-time controller for the even clock divider. Owns the half-period
//   counter and clk_out (period 2*div_cur sys_clk cycles, 50% duty).
//   Ratio changes arrive on div_req/div_val. While stopped they take effect
//   at once. While running they are held in div_nxt and applied only on a
//   falling toggle of clk_out, so no phase is ever cut short.
//   run_en starts and stops the output cleanly. A high phase that is in
//   progress always completes before the block enters STOP.
//
//   Handshake: div_req is a one-cycle strobe sampled on posedge sys_clk with
//   no ready/backpressure. The block answers every request with exactly one
//   response: div_err on the next cycle (div_val==0), or div_ack when the
//   value becomes div_cur. A request that is overwritten while pending
//   receives no response.
//
//   Optional build macro: DIV_EDGE_PULSE_EN adds rise_pls/fall_pls outputs.
//   These are registered one-cycle pulses on each clk_out 0->1 / 1->0 toggle.
//
//   dbg_state exposes the FSM state (0 STOP, 1 RUN, 2 PEND).
// ---------------------------------------------------------------------------
module divider_ratio_ctrl #(
    parameter int          CNT_W       = 8,
    parameter int unsigned DIV_DEFAULT = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             run_en,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic [CNT_W-1:0] div_cur,
    output logic             clk_out,
`ifdef DIV_EDGE_PULSE_EN
    output logic             rise_pls,
    output logic             fall_pls,
`endif
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] div_nxt, div_nxt_d;
    logic [CNT_W-1:0] div_cur_d;
    logic             clk_d;
    logic             ack_d;
    logic             err_d;

    // Request qualification and free-running count helpers
    logic             req_ok;
    logic             req_bad;
    logic             tc;
    logic [CNT_W-1:0] cnt_step;
    logic             clk_step;
    logic             pend_eff;
    logic [CNT_W-1:0] nxt_eff;
    logic             stop_now;

    assign req_ok   = div_req && (div_val != '0);
    assign req_bad  = div_req && (div_val == '0);
    // Terminal count is an exact compare at full width. div_cur is never 0,
    // so the subtraction never wraps.
    assign tc       = (cnt == (div_cur - CNT_W'(1)));
    assign cnt_step = tc ? '0 : (cnt + CNT_W'(1));
    assign clk_step = tc ? ~clk_out : clk_out;
    // A request on the same edge as a stop is captured before the stop rules
    // are applied. It therefore counts as pending, and it wins over an older
    // div_nxt.
    assign pend_eff = (state == ST_PEND) || req_ok;
    assign nxt_eff  = req_ok ? div_val : div_nxt;
    // Stop immediately while low. While high, stop only on the falling toggle.
    assign stop_now = !run_en && (!clk_out || tc);

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_STOP;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, counter, clock and handshake decisions
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        clk_d     = clk_out;
        div_cur_d = div_cur;
        div_nxt_d = div_nxt;
        ack_d     = 1'b0;
        err_d     = req_bad;

        case (state)
            ST_STOP: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (req_ok) begin
                    div_cur_d = div_val;
                    ack_d     = 1'b1;
                end
                if (run_en) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_PEND: begin
                if (req_ok) begin
                    div_nxt_d = div_val;
                end
                if (stop_now) begin
                    // Clean stop. Any pending ratio is applied on the way in.
                    state_d = ST_STOP;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                    if (pend_eff) begin
                        div_cur_d = nxt_eff;
                        ack_d     = 1'b1;
                    end
                end else if ((state == ST_PEND) && tc && clk_out) begin
                    // Falling toggle: swap in the pending ratio. A request on
                    // this same edge stays pending and is applied on the next
                    // falling toggle.
                    div_cur_d = div_nxt;
                    cnt_d     = '0;
                    clk_d     = 1'b0;
                    ack_d     = 1'b1;
                    state_d   = req_ok ? ST_PEND : ST_RUN;
                end else begin
                    cnt_d = cnt_step;
                    clk_d = clk_step;
                    if (req_ok) begin
                        state_d = ST_PEND;
                    end
                end
            end

            default: begin
                state_d = ST_STOP;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase
    end

    // Datapath and handshake registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            div_cur <= DIV_RST;
            div_nxt <= '0;
            div_ack <= 1'b0;
            div_err <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            clk_out <= clk_d;
            div_cur <= div_cur_d;
            div_nxt <= div_nxt_d;
            div_ack <= ack_d;
            div_err <= err_d;
        end
    end

`ifdef DIV_EDGE_PULSE_EN
    // Edge pulses are registered on the same edge as the clk_out toggle they mark
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rise_pls <= 1'b0;
            fall_pls <= 1'b0;
        end else begin
            rise_pls <= clk_d & ~clk_out;
            fall_pls <= ~clk_d & clk_out;
        end
    end
`endif

    assign busy      = (state == ST_PEND);
    assign dbg_state = state;

endmodule

// File: tb/tb_divider_ratio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_divider_ratio_ctrl
//   Cycle-by-cycle directed trace for divider_ratio_ctrl (DIV_DEFAULT=3).
//   Each table row gives the inputs driven for one sys_clk cycle and the
//   outputs expected just after the following rising edge. A hand-written
//   sequence then covers an asynchronous reset taken while in PEND.
// ---------------------------------------------------------------------------
module tb_divider_ratio_ctrl;

    localparam int CNT_W = 8;
    localparam logic [1:0] S = 2'd0;
    localparam logic [1:0] R = 2'd1;
    localparam logic [1:0] P = 2'd2;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             run_en;
    logic             div_req;
    logic [CNT_W-1:0] div_val;
    logic             div_ack;
    logic             div_err;
    logic             busy;
    logic [CNT_W-1:0] div_cur;
    logic             clk_out;
    logic [1:0]       dbg_state;
`ifdef DIV_EDGE_PULSE_EN
    logic             rise_pls;
    logic             fall_pls;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    divider_ratio_ctrl #(.CNT_W(CNT_W), .DIV_DEFAULT(3)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .run_en    (run_en),
        .div_req   (div_req),
        .div_val   (div_val),
        .div_ack   (div_ack),
        .div_err   (div_err),
        .busy      (busy),
        .div_cur   (div_cur),
        .clk_out   (clk_out),
`ifdef DIV_EDGE_PULSE_EN
        .rise_pls  (rise_pls),
        .fall_pls  (fall_pls),
`endif
        .dbg_state (dbg_state)
    );

    // Clock generation
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic             run;
        logic             req;
        logic [CNT_W-1:0] val;
        logic             clk;
        logic             ack;
        logic             err;
        logic             bsy;
        logic [CNT_W-1:0] cur;
        logic [1:0]       st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic run, logic req, int val, logic clk, logic ack,
                                logic err, logic bsy, int cur, logic [1:0] st);
        vec_t v;
        v.run = run; v.req = req; v.val = CNT_W'(val);
        v.clk = clk; v.ack = ack; v.err = err; v.bsy = bsy;
        v.cur = CNT_W'(cur); v.st = st;
        return v;
    endfunction

    // Plain running row: inputs run=1, no request
    function automatic vec_t rn(logic clk, int cur, logic [1:0] st);
        return mk(1'b1, 1'b0, 0, clk, 1'b0, 1'b0, st == P, cur, st);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic build_table();
        // 1: start from STOP, DIV_DEFAULT=3. First rise at E0+3, then period 6.
        vecs.push_back(rn(0, 3, R));                               // v0  E0
        vecs.push_back(rn(0, 3, R));
        vecs.push_back(rn(0, 3, R));
        vecs.push_back(rn(1, 3, R));                               // v3  rise
        vecs.push_back(rn(1, 3, R));
        vecs.push_back(rn(1, 3, R));
        vecs.push_back(rn(0, 3, R));                               // v6  fall
        vecs.push_back(rn(0, 3, R));
        vecs.push_back(rn(0, 3, R));
        vecs.push_back(rn(1, 3, R));                               // v9  rise
        // 3: invalid request
        vecs.push_back(mk(1, 1, 0, 1, 0, 1, 0, 3, R));             // v10 err
        vecs.push_back(rn(1, 3, R));
        vecs.push_back(rn(0, 3, R));
        vecs.push_back(rn(0, 3, R));
        vecs.push_back(rn(0, 3, R));
        vecs.push_back(rn(1, 3, R));                               // v15
        // 2: request 5 mid-high, applied on the falling toggle
        vecs.push_back(mk(1, 1, 5, 1, 0, 0, 1, 3, P));             // v16
        vecs.push_back(rn(1, 3, P));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 5, R));             // v18 apply
        for (int i = 0; i < 4; i++) vecs.push_back(rn(0, 5, R));
        vecs.push_back(rn(1, 5, R));                               // v23
        for (int i = 0; i < 4; i++) vecs.push_back(rn(1, 5, R));
        vecs.push_back(rn(0, 5, R));                               // v28
        // 4: request 4 then overwrite with 2 before the apply
        vecs.push_back(mk(1, 1, 4, 0, 0, 0, 1, 5, P));             // v29
        vecs.push_back(mk(1, 1, 2, 0, 0, 0, 1, 5, P));             // v30
        vecs.push_back(rn(0, 5, P));
        vecs.push_back(rn(0, 5, P));
        vecs.push_back(rn(1, 5, P));                               // v33 rising, no apply
        for (int i = 0; i < 4; i++) vecs.push_back(rn(1, 5, P));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 2, R));             // v38 single ack
        vecs.push_back(rn(0, 2, R));
        vecs.push_back(rn(1, 2, R));
        vecs.push_back(rn(1, 2, R));
        vecs.push_back(rn(0, 2, R));                               // v42
        // back to 3 for the stop tests
        vecs.push_back(mk(1, 1, 3, 0, 0, 0, 1, 2, P));             // v43
        vecs.push_back(rn(1, 2, P));
        vecs.push_back(rn(1, 2, P));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 3, R));             // v46
        vecs.push_back(rn(0, 3, R));
        vecs.push_back(rn(0, 3, R));
        vecs.push_back(rn(1, 3, R));                               // v49 rise
        // 5: stop while high; the high phase completes its full 3 cycles
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3, R));             // v50
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3, R));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, S));             // v52 stop
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, S));
        // stop while low: STOP on the next edge
        vecs.push_back(rn(0, 3, R));                               // v54
        vecs.push_back(rn(0, 3, R));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, S));             // v56
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, S));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, S));
        // request while stopped is applied directly
        vecs.push_back(mk(0, 1, 4, 0, 1, 0, 0, 4, S));             // v59
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, S));
        // request and stop on the same edge while high; applied on STOP entry
        vecs.push_back(rn(0, 4, R));                               // v61
        for (int i = 0; i < 3; i++) vecs.push_back(rn(0, 4, R));
        vecs.push_back(rn(1, 4, R));                               // v65 rise
        vecs.push_back(mk(0, 1, 6, 1, 0, 0, 1, 4, P));             // v66
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 4, P));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 4, P));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 6, S));             // v69
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6, S));
    endtask

    initial begin
        logic prev_clk;

        sys_rst_n = 1'b0;
        run_en    = 1'b0;
        div_req   = 1'b0;
        div_val   = '0;
        build_table();

        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_div_cur", 32'(div_cur), 3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(div_ack), 0);
        chk("rst_err", 32'(div_err), 0);
        chk("rst_state", 32'(dbg_state), 32'(S));
        sys_rst_n = 1'b1;

        // Table-driven trace
        prev_clk = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            run_en  = vecs[i].run;
            div_req = vecs[i].req;
            div_val = vecs[i].val;
            tick();
            chk($sformatf("v%0d clk_out", i), 32'(clk_out), 32'(vecs[i].clk));
            chk($sformatf("v%0d div_ack", i), 32'(div_ack), 32'(vecs[i].ack));
            chk($sformatf("v%0d div_err", i), 32'(div_err), 32'(vecs[i].err));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("v%0d div_cur", i), 32'(div_cur), 32'(vecs[i].cur));
            chk($sformatf("v%0d state", i), 32'(dbg_state), 32'(vecs[i].st));
`ifdef DIV_EDGE_PULSE_EN
            chk($sformatf("v%0d rise_pls", i), 32'(rise_pls), 32'(vecs[i].clk & ~prev_clk));
            chk($sformatf("v%0d fall_pls", i), 32'(fall_pls), 32'(~vecs[i].clk & prev_clk));
`endif
            prev_clk = vecs[i].clk;
        end
        div_req = 1'b0;
        div_val = '0;

        // 6: asynchronous reset while PEND with clk_out high (div_cur=6)
        run_en = 1'b1;
        repeat (7) tick();
        chk("pre_rst_clk_high", 32'(clk_out), 1);
        div_req = 1'b1;
        div_val = 8'd2;
        tick();
        div_req = 1'b0;
        div_val = '0;
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_state", 32'(dbg_state), 32'(P));
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_clk_out", 32'(clk_out), 0);
        chk("mid_rst_div_cur", 32'(div_cur), 3);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ack", 32'(div_ack), 0);
        chk("mid_rst_state", 32'(dbg_state), 32'(S));
        run_en = 1'b0;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("post_rst%0d ack", i), 32'(div_ack), 0);
            chk($sformatf("post_rst%0d clk_out", i), 32'(clk_out), 0);
            chk($sformatf("post_rst%0d div_cur", i), 32'(div_cur), 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
